// File: rtl/nor_cor.sv
// Normalization and round-to-nearest-even stage for the IIR filter float datapath.
// Packs {sign, exp, mant} with a hidden leading 1; registered, one-cycle latency.
module nor_cor #(
   parameter int WIDTH     = 13,
   parameter int WIDTH_mat = 5,
   parameter int WIDTH_exp = 4
) (
   input  logic                              CLK,
   input  logic                              RST,
   input  logic                              sign_L,
   input  logic [WIDTH-1:0]                  mat_in,
   input  logic [WIDTH_exp-1:0]              exp,
   input  logic                              clear,
   input  logic                              exce_in,
   output logic                              exce_out,
   output logic [WIDTH_mat+WIDTH_exp:0]      result
);

   localparam int RES_W     = WIDTH_mat + WIDTH_exp + 1;
   localparam int NORM_W    = WIDTH - 1;
   localparam int MANT_TOP  = WIDTH - 3;
   localparam int GUARD_POS = WIDTH - 3 - WIDTH_mat;
   localparam int K_W       = $clog2(WIDTH);
   // exponent must hold both exp+carries and exp-(WIDTH-2) without wrapping
   localparam int EXP_W     = (WIDTH_exp + 2 > K_W + 2) ? WIDTH_exp + 2 : K_W + 2;

   localparam logic signed [EXP_W-1:0] EXP_MAX = EXP_W'((1 << WIDTH_exp) - 1);

   logic                      carry;
   logic                      is_zero;
   logic                      lead_found;
   logic [K_W-1:0]            lead_dist;
   logic [NORM_W-1:0]         norm;
   logic                      lost_bit;
   logic [WIDTH_mat-1:0]      mant_trunc;
   logic                      guard;
   logic                      sticky;
   logic                      round_up;
   logic [WIDTH_mat:0]        mant_sum;
   logic signed [EXP_W-1:0]   exp_ext;
   logic signed [EXP_W-1:0]   exp_norm;
   logic signed [EXP_W-1:0]   exp_final;
   logic [WIDTH_mat-1:0]      mant_final;
   logic                      ovf;
   logic                      unf;
   logic [RES_W-1:0]          result_nxt;
   logic                      exce_nxt;

   assign carry   = mat_in[WIDTH-1];
   assign is_zero = (mat_in == '0);
   assign exp_ext = signed'({{(EXP_W-WIDTH_exp){1'b0}}, exp});

   // distance of the leading 1 below the hidden-1 position
   always_comb begin
      lead_dist  = '0;
      lead_found = 1'b0;
      for (int i = WIDTH - 2; i >= 0; i--) begin
         if (!lead_found && mat_in[i]) begin
            lead_dist  = K_W'(WIDTH - 2 - i);
            lead_found = 1'b1;
         end
      end
   end

   always_comb begin
      norm     = '0;
      lost_bit = 1'b0;
      exp_norm = exp_ext;
      if (carry) begin
         norm     = mat_in[WIDTH-1:1];
         lost_bit = mat_in[0];
         exp_norm = exp_ext + EXP_W'(1);
      end else begin
         norm     = mat_in[WIDTH-2:0] << lead_dist;
         exp_norm = exp_ext - signed'({{(EXP_W-K_W){1'b0}}, lead_dist});
      end
   end

   assign mant_trunc = norm[MANT_TOP -: WIDTH_mat];
   assign guard      = norm[GUARD_POS];

   always_comb begin
      sticky = lost_bit;
      for (int i = 0; i < GUARD_POS; i++) begin
         sticky = sticky | norm[i];
      end
   end

   assign round_up = guard & (sticky | mant_trunc[0]);
   assign mant_sum = {1'b0, mant_trunc} + {{WIDTH_mat{1'b0}}, round_up};

   // a carry out of the mantissa leaves all-zero fraction bits and bumps the exponent
   always_comb begin
      mant_final = mant_sum[WIDTH_mat-1:0];
      exp_final  = exp_norm;
      if (mant_sum[WIDTH_mat]) begin
         mant_final = '0;
         exp_final  = exp_norm + EXP_W'(1);
      end
   end

   assign ovf = !is_zero && (exp_final > EXP_MAX);
   assign unf = !is_zero && (exp_final < 0);

   always_comb begin
      result_nxt = {sign_L, exp_final[WIDTH_exp-1:0], mant_final};
      if (is_zero || unf) begin
         result_nxt = {sign_L, {(RES_W-1){1'b0}}};
      end else if (ovf) begin
         result_nxt = {sign_L, {(RES_W-1){1'b1}}};
      end
      exce_nxt = exce_in | ovf | unf;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         result   <= '0;
         exce_out <= 1'b0;
      end else if (clear) begin
         result   <= '0;
         exce_out <= 1'b0;
      end else begin
         result   <= result_nxt;
         exce_out <= exce_nxt;
      end
   end

endmodule

// File: tb/tb_nor_cor.sv
// Directed checks of nor_cor against hand-computed normalized/rounded results.
module tb_nor_cor;

   logic        clk;
   logic        rst_n;
   logic        sign_l;
   logic [12:0] mat_in;
   logic [3:0]  exp_in;
   logic        clear;
   logic        exce_in;
   logic        exce_out;
   logic [9:0]  result;

   int checks = 0;
   int errors = 0;

   nor_cor #(.WIDTH(13), .WIDTH_mat(5), .WIDTH_exp(4)) dut (
      .CLK      (clk),
      .RST      (rst_n),
      .sign_L   (sign_l),
      .mat_in   (mat_in),
      .exp      (exp_in),
      .clear    (clear),
      .exce_in  (exce_in),
      .exce_out (exce_out),
      .result   (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_res(input string tag, input logic [9:0] obs, input logic [9:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s result got %b want %b", tag, obs, want);
      end
   endtask

   task automatic check_exc(input string tag, input logic obs, input logic want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s exce_out got %b want %b", tag, obs, want);
      end
   endtask

   task automatic drive(input logic s, input logic [12:0] m, input logic [3:0] e,
                        input logic ei, input logic cl);
      sign_l  = s;
      mat_in  = m;
      exp_in  = e;
      exce_in = ei;
      clear   = cl;
   endtask

   task automatic step(input string tag, input logic s, input logic [12:0] m,
                       input logic [3:0] e, input logic ei, input logic cl,
                       input logic [9:0] want_res, input logic want_exc);
      drive(s, m, e, ei, cl);
      @(posedge clk);
      #1;
      check_res(tag, result, want_res);
      check_exc(tag, exce_out, want_exc);
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b1, 13'b1_111111_111111, 4'd15, 1'b1, 1'b0);
      #2;
      check_res("reset_async", result, 10'b0);
      check_exc("reset_async", exce_out, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      step("basic",        1'b0, 13'b0_101011_000000, 4'd3,  1'b0, 1'b0, 10'b0_0011_01011, 1'b0);
      step("carry_round",  1'b0, 13'b1_101011_110000, 4'd3,  1'b0, 1'b0, 10'b0_0100_10110, 1'b0);
      step("carry_neg",    1'b1, 13'b1_101011_110000, 4'd3,  1'b0, 1'b0, 10'b1_0100_10110, 1'b0);
      step("left_norm_a",  1'b0, 13'b0_001111_100000, 4'd3,  1'b0, 1'b0, 10'b0_0001_11110, 1'b0);
      step("left_norm_b",  1'b0, 13'b0_001111_101001, 4'd3,  1'b0, 1'b0, 10'b0_0001_11111, 1'b0);
      step("tie_even_cry", 1'b0, 13'b0_001111_111000, 4'd3,  1'b0, 1'b0, 10'b0_0010_00000, 1'b0);
      step("trunc_a",      1'b0, 13'b0_101111_010000, 4'd3,  1'b0, 1'b0, 10'b0_0011_01111, 1'b0);
      step("trunc_b",      1'b0, 13'b0_101111_010001, 4'd3,  1'b0, 1'b0, 10'b0_0011_01111, 1'b0);
      step("tie_even_dn",  1'b0, 13'b0_101110_100000, 4'd3,  1'b0, 1'b0, 10'b0_0011_01110, 1'b0);
      step("underflow",    1'b0, 13'b0_000011_011000, 4'd3,  1'b0, 1'b0, 10'b0_0000_00000, 1'b1);
      step("underflow_ng", 1'b1, 13'b0_000011_011000, 4'd3,  1'b0, 1'b0, 10'b1_0000_00000, 1'b1);
      step("overflow",     1'b0, 13'b1_001111_000000, 4'd15, 1'b0, 1'b0, 10'b0_1111_11111, 1'b1);
      step("ovf_by_round", 1'b1, 13'b0_111111_100000, 4'd15, 1'b0, 1'b0, 10'b1_1111_11111, 1'b1);
      step("max_exp",      1'b0, 13'b0_111110_000000, 4'd15, 1'b0, 1'b0, 10'b0_1111_11110, 1'b0);
      step("min_exp",      1'b0, 13'b0_100000_000000, 4'd0,  1'b0, 1'b0, 10'b0_0000_00000, 1'b0);
      step("deep_left",    1'b0, 13'b0_000000_000001, 4'd12, 1'b0, 1'b0, 10'b0_0001_00000, 1'b0);
      step("zero_in",      1'b1, 13'b0_000000_000000, 4'd5,  1'b0, 1'b0, 10'b1_0000_00000, 1'b0);
      step("exce_in",      1'b0, 13'b0_101011_000000, 4'd3,  1'b1, 1'b0, 10'b0_0011_01011, 1'b1);
      step("clear_prio",   1'b1, 13'b1_001111_000000, 4'd15, 1'b1, 1'b1, 10'b0_0000_00000, 1'b0);
      step("after_clear",  1'b0, 13'b0_101011_000000, 4'd3,  1'b0, 1'b0, 10'b0_0011_01011, 1'b0);

      // reset mid-stream: the in-flight value is discarded at once
      drive(1'b0, 13'b0_001111_100000, 4'd3, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_res("reset_mid", result, 10'b0);
      check_exc("reset_mid", exce_out, 1'b0);
      @(posedge clk);
      #1;
      check_res("reset_held", result, 10'b0);
      check_exc("reset_held", exce_out, 1'b0);
      #2;
      rst_n = 1'b1;
      step("post_reset",   1'b0, 13'b0_001111_100000, 4'd3,  1'b0, 1'b0, 10'b0_0001_11110, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
